// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch sequencer.
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StFetch = 2'd1;
  localparam state_t StHold  = 2'd2;
  localparam state_t StFault = 2'd3;

  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [31:0] NOP_WORD = 32'h38000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        v2;
  } pair_t;

  function automatic logic is_jump(input logic [31:0] instr);
    return instr[31:26] == OP_J;
  endfunction

endpackage

// File: rtl/fetch_dual_ctrl_if.sv
// Fetch-sequencer bus: instruction memory ports, redirect input, decode handshake, fault status.
interface fetch_dual_ctrl_if;
  logic        fetch_en;
  logic [31:0] mem_addr_1;
  logic [31:0] mem_addr_2;
  logic        mem_rd_n_1;
  logic        mem_rd_n_2;
  logic [31:0] mem_data_1;
  logic [31:0] mem_data_2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr_1;
  logic [31:0] dec_instr_2;
  logic        dec_slot2_vld;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    input  fetch_en, mem_data_1, mem_data_2, redirect_valid, redirect_pc, dec_ready,
    output mem_addr_1, mem_addr_2, mem_rd_n_1, mem_rd_n_2, dec_valid, dec_pc,
           dec_instr_1, dec_instr_2, dec_slot2_vld, fault, fault_pc
  );

  modport slave (
    output fetch_en, mem_data_1, mem_data_2, redirect_valid, redirect_pc, dec_ready,
    input  mem_addr_1, mem_addr_2, mem_rd_n_1, mem_rd_n_2, dec_valid, dec_pc,
           dec_instr_1, dec_instr_2, dec_slot2_vld, fault, fault_pc
  );
endinterface

// File: rtl/fetch_pair_fifo.sv
// Depth-entry queue of fetched instruction pairs; push is accepted when full if a pop coincides.
module fetch_pair_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  push,
  input  logic  pop,
  input  pair_t wdata,
  output pair_t rdata,
  output logic  empty,
  output logic  full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  pair_t            mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = count_q == '0;
  assign full    = count_q == CntW'(Depth);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: empty gates every consumer of rdata.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_dual_ctrl.sv
// Dual-issue fetch sequencer: owns the PC, reads PC/PC+4 each fetch cycle, queues pairs for
// decode, predecodes slot-1 jumps, applies redirects and traps unmapped fetches.
module fetch_dual_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] ResetPc  = 32'h00400000,
  parameter int unsigned Depth    = 2,
  parameter logic [31:0] Unmapped = 32'hFFFFFFFF,
  parameter logic [31:0] NopWord  = NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_dual_ctrl_if.master     bus
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  pair_t       head, wdata;
  logic        empty, full;
  logic        pop, push, fetch_active;
  logic        port1_bad, port2_bad;
  logic [31:0] pc_plus4, pc_plus8, jump_pc;
  logic        unused_rpc;

  assign unused_rpc = ^bus.redirect_pc[1:0];

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_plus8  = pc_q + 32'd8;
  assign jump_pc   = {pc_plus4[31:28], bus.mem_data_1[25:0], 2'b00};
  assign port1_bad = bus.mem_data_1 == Unmapped;
  assign port2_bad = bus.mem_data_2 == Unmapped;

  assign pop          = bus.dec_ready && !empty;
  // A pop frees the slot this cycle, so a full queue can still take the new pair.
  assign fetch_active = (state_q == StFetch) && bus.fetch_en && (!full || pop);
  assign push         = fetch_active && !port1_bad && !bus.redirect_valid;

  assign wdata = '{pc: pc_q,
                   i1: bus.mem_data_1,
                   i2: port2_bad ? NopWord : bus.mem_data_2,
                   v2: !port2_bad};

  fetch_pair_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop && !bus.redirect_valid),
    .wdata (wdata),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      fault_d = 1'b0;
      state_d = bus.fetch_en ? StFetch : StIdle;
    end else begin
      case (state_q)
        StIdle: if (bus.fetch_en) state_d = StFetch;
        StFetch: begin
          if (fetch_active) begin
            if (port1_bad) begin
              state_d    = StFault;
              fault_d    = 1'b1;
              fault_pc_d = pc_q;
            end else if (port2_bad) begin
              state_d    = StFault;
              fault_d    = 1'b1;
              fault_pc_d = pc_plus4;
            end else begin
              pc_d = is_jump(bus.mem_data_1) ? jump_pc : pc_plus8;
            end
          end else if (full && !pop) begin
            state_d = StHold;
          end
        end
        StHold:  if (pop) state_d = StFetch;
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= ResetPc;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.mem_addr_1    = pc_q;
  assign bus.mem_addr_2    = pc_plus4;
  assign bus.mem_rd_n_1    = !fetch_active;
  assign bus.mem_rd_n_2    = !fetch_active;
  assign bus.dec_valid     = !empty;
  assign bus.dec_pc        = empty ? '0 : head.pc;
  assign bus.dec_instr_1   = empty ? '0 : head.i1;
  assign bus.dec_instr_2   = empty ? '0 : head.i2;
  assign bus.dec_slot2_vld = !empty && head.v2;
  assign bus.fault         = fault_q;
  assign bus.fault_pc      = fault_pc_q;

endmodule
